issue_ctrl: RTL

Decode-to-execute issue controller for the ThetaCore pipeline. Accepts one decoded instruction at a time from the fetch/IDU front end and holds it in a one-entry buffer. Issues it to the CU/ALU once no register hazard exists. Tracks in-flight destination registers in a 32-entry scoreboard, raises a one-cycle trap on illegal decodes, and discards the buffered instruction on a pipeline flush.

---
 rtl/thetacore_pkg.sv | 27 ++
 rtl/reg_scoreboard.sv | 68 ++++++
 rtl/issue_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/thetacore_pkg.sv
// thetacore_pkg: types and constants shared by the ThetaCore issue logic.
//   issue_state_t : issue controller FSM encoding (IDLE, HOLD, TRAP)
//   REG_X0        : index of the hard-wired zero register
//   CU_OP_W       : width of the CU instruction code
//   issue_buf_t   : one-entry decode buffer contents
package thetacore_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2
  } issue_state_t;

  localparam logic [4:0] REG_X0  = 5'd0;
  localparam int         CU_OP_W = 6;

  typedef struct packed {
    logic [CU_OP_W-1:0] cu_op;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic               uses_rs1;
    logic               uses_rs2;
    logic               writes_rd;
  } issue_buf_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: 32 pending-write bits plus an in-flight writer counter.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   set_valid_i/set_rd_i: issue of a writer; marks set_rd_i pending
//   clr_valid_i/clr_rd_i: writeback; clears clr_rd_i if it was pending
//   rs1_i/rs2_i/rd_i    : lookup indices, *_busy_o = register pending
//   count_o             : number of pending registers
//   full_o              : count_o has reached MAX_INFLIGHT
//   pending_o           : raw pending bits, for observation
// x0 is never marked pending and always reads as not busy. Lookups see
// registered state only, so a writeback is visible the cycle after its edge.
module reg_scoreboard
  import thetacore_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_valid_i,
  input  logic [4:0]       set_rd_i,
  input  logic             clr_valid_i,
  input  logic [4:0]       clr_rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             rd_busy_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic [31:0]      pending_o
);

  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_hit, clr_hit;

  assign set_hit = set_valid_i && (set_rd_i != REG_X0);
  // Stray writebacks (x0 or a register not pending) must not touch the count.
  assign clr_hit = clr_valid_i && (clr_rd_i != REG_X0) && pend_q[clr_rd_i];

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (clr_hit) pend_d[clr_rd_i] = 1'b0;
    if (set_hit) pend_d[set_rd_i] = 1'b1;
    if (set_hit && !clr_hit)      cnt_d = cnt_q + CNT_W'(1);
    else if (clr_hit && !set_hit) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rs1_busy_o = (rs1_i != REG_X0) && pend_q[rs1_i];
  assign rs2_busy_o = (rs2_i != REG_X0) && pend_q[rs2_i];
  assign rd_busy_o  = (rd_i  != REG_X0) && pend_q[rd_i];
  assign count_o    = cnt_q;
  assign full_o     = (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign pending_o  = pend_q;

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-to-execute issue controller with a one-entry buffer.
//   soc_clk, reset            : clock, asynchronous active-high reset
//   fetch_valid/fetch_ready   : decode handshake, dec_* captured on accept
//   dec_*                     : decoded instruction fields and flags
//   issue_valid/exec_ready    : execute handshake, issue_* show the buffer
//   wb_valid, wb_rd           : writeback completion
//   flush                     : discard the buffered instruction
//   stall                     : buffer occupied and blocked by a hazard
//   illegal_trap              : one-cycle pulse after an illegal decode
//   inflight_count            : issued writers not yet written back
//   dbg_state, dbg_pending    : FSM state and scoreboard bits for observation
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and an offered instruction stays
// offered until it transfers or is flushed.
module issue_ctrl
  import thetacore_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                              soc_clk,
  input  logic                              reset,
  input  logic                              fetch_valid,
  output logic                              fetch_ready,
  input  logic [4:0]                        dec_rd,
  input  logic [4:0]                        dec_rs1,
  input  logic [4:0]                        dec_rs2,
  input  logic                              dec_uses_rs1,
  input  logic                              dec_uses_rs2,
  input  logic                              dec_writes_rd,
  input  logic                              dec_invalid,
  input  logic [CU_OP_W-1:0]                dec_cu_op,
  output logic                              issue_valid,
  input  logic                              exec_ready,
  output logic [CU_OP_W-1:0]                issue_cu_op,
  output logic [4:0]                        issue_rd,
  output logic [4:0]                        issue_rs1,
  output logic [4:0]                        issue_rs2,
  input  logic                              wb_valid,
  input  logic [4:0]                        wb_rd,
  input  logic                              flush,
  output logic                              stall,
  output logic                              illegal_trap,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_count,
  output issue_state_t                      dbg_state,
  output logic [31:0]                       dbg_pending
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  issue_state_t state_q, state_d;
  issue_buf_t   buf_q, buf_d;
  logic         rs1_busy, rs2_busy, rd_busy, sb_full;
  logic         hazard, do_issue;

  reg_scoreboard #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .CNT_W       (CNT_W)
  ) u_sb (
    .clk_i      (soc_clk),
    .rst_i      (reset),
    .set_valid_i(do_issue && buf_q.writes_rd),
    .set_rd_i   (buf_q.rd),
    .clr_valid_i(wb_valid),
    .clr_rd_i   (wb_rd),
    .rs1_i      (buf_q.rs1),
    .rs2_i      (buf_q.rs2),
    .rd_i       (buf_q.rd),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .rd_busy_o  (rd_busy),
    .count_o    (inflight_count),
    .full_o     (sb_full),
    .pending_o  (dbg_pending)
  );

  // RAW on either source, WAW on rd, or no free in-flight slot for a writer.
  // Writes to x0 are untracked, so they never need a slot.
  assign hazard = (buf_q.uses_rs1 && rs1_busy) ||
                  (buf_q.uses_rs2 && rs2_busy) ||
                  (buf_q.writes_rd && rd_busy) ||
                  (sb_full && buf_q.writes_rd && (buf_q.rd != REG_X0));

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fetch_ready = 1'b0;
    issue_valid = 1'b0;
    stall       = 1'b0;
    do_issue    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Held low during reset so nothing is offered a handshake then.
        fetch_ready = !reset;
        if (fetch_valid && !flush) begin
          buf_d.cu_op     = dec_cu_op;
          buf_d.rd        = dec_rd;
          buf_d.rs1       = dec_rs1;
          buf_d.rs2       = dec_rs2;
          buf_d.uses_rs1  = dec_uses_rs1;
          buf_d.uses_rs2  = dec_uses_rs2;
          buf_d.writes_rd = dec_writes_rd;
          state_d         = dec_invalid ? TRAP : HOLD;
        end
      end
      HOLD: begin
        stall       = hazard;
        issue_valid = !hazard && !flush;
        if (flush) begin
          state_d = IDLE;
        end else if (issue_valid && exec_ready) begin
          do_issue = 1'b1;
          state_d  = IDLE;
        end
      end
      TRAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // TRAP lasts exactly one cycle, so the pulse is a decode of the state flop.
  assign illegal_trap = (state_q == TRAP);
  assign issue_cu_op  = buf_q.cu_op;
  assign issue_rd     = buf_q.rd;
  assign issue_rs1    = buf_q.rs1;
  assign issue_rs2    = buf_q.rs2;
  assign dbg_state    = state_q;

endmodule
